// File: rtl/pixel_stream_packer_pkg.sv
// Shared types for the shade-stream packer: beat layout, FSM states and a saturating helper.
// COLOR_WIDTH sets the default shade width when the including build does not define it.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 24
`endif

package pixel_stream_packer_pkg;

  localparam int PIX_W_DEF      = `COLOR_WIDTH;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int TDATA_W_DEF    = 32;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef struct packed {
    logic   sof;
    logic   eol;
    pixel_t pixel;
  } pix_beat_t;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    STREAM   = 2'd1,
    DROP     = 2'd2
  } packer_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
// Writes are refused while full even if a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; the head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pixel_stream_packer.sv
// Buffers the non-stallable shade stream and presents it as an AXI4-Stream video master.
// Optional frame/drop statistics ports are built when PACKER_STATS_EN is defined.
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TDATA_W    = TDATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   shade_in,
  input  logic               valid_in,
  input  logic               sof_in,
  input  logic               eol_in,
  output logic               ready_out,
  input  logic               overflow_clr,
  output logic               overflow,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output packer_state_t      state_dbg
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]        frame_count,
  output logic [15:0]        drop_count
`endif
);

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] pixel;
  } beat_t;

  packer_state_t state, state_nxt;
  beat_t         wr_beat, rd_beat;
  logic          fifo_wr, fifo_full, fifo_empty;
  logic          beat_drop, ovf_set, pop;

  assign wr_beat = '{sof: sof_in, eol: eol_in, pixel: shade_in};

  sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_wr   = 1'b0;
    beat_drop = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (valid_in && sof_in) begin
          fifo_wr   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (valid_in) begin
          if (fifo_full) begin
            beat_drop = 1'b1;
            ovf_set   = 1'b1;
            state_nxt = DROP;
          end else begin
            fifo_wr = 1'b1;
          end
        end
      end
      DROP: begin
        // Only a frame start that fits re-enters the stream; everything else is lost.
        if (valid_in) begin
          if (sof_in && !fifo_full) begin
            fifo_wr   = 1'b1;
            state_nxt = STREAM;
          end else begin
            beat_drop = 1'b1;
          end
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  // AXIS valid/ready: a beat transfers on a cycle with tvalid && tready; tvalid only falls after
  // a transfer and the head entry does not move until then, so payload holds while stalled.
  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? TDATA_W'(rd_beat.pixel) : '0;
  assign m_axis_tuser  = m_axis_tvalid && rd_beat.sof;
  assign m_axis_tlast  = m_axis_tvalid && rd_beat.eol;
  assign ready_out     = !fifo_full;
  assign state_dbg     = state;

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (pop && m_axis_tuser) frame_count <= frame_count + 32'd1;
      if (beat_drop)           drop_count  <= sat_inc16(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer: output beats are checked against an expected queue,
// and payload stability under backpressure is checked on every stalled cycle.
`timescale 1ns/1ps
module tb_pixel_stream_packer;
  import pixel_stream_packer_pkg::*;

  localparam int PIX_W   = 24;
  localparam int TDATA_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [PIX_W-1:0]   shade_in = '0;
  logic               valid_in = 1'b0;
  logic               sof_in = 1'b0;
  logic               eol_in = 1'b0;
  logic               ready_out;
  logic               overflow_clr = 1'b0;
  logic               overflow;
  logic [TDATA_W-1:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic               m_axis_tuser;
  logic               m_axis_tlast;
  packer_state_t      state_dbg;
`ifdef PACKER_STATS_EN
  logic [31:0]        frame_count;
  logic [15:0]        drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];
  logic [33:0] prev_out = '0;
  logic        prev_stall = 1'b0;

  pixel_stream_packer #(.PIX_W(PIX_W), .FIFO_DEPTH(16), .TDATA_W(TDATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .shade_in      (shade_in),
    .valid_in      (valid_in),
    .sof_in        (sof_in),
    .eol_in        (eol_in),
    .ready_out     (ready_out),
    .overflow_clr  (overflow_clr),
    .overflow      (overflow),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .state_dbg     (state_dbg)
`ifdef PACKER_STATS_EN
    ,
    .frame_count   (frame_count),
    .drop_count    (drop_count)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: inputs change at posedge+1, so the negedge sees what the next posedge samples
  always @(negedge clk) begin
    logic [33:0] obs;
    logic [25:0] e;
    obs = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        assert (m_axis_tvalid === 1'b1 && obs === prev_out) else begin
          n_err++;
          $error("FAIL hold: observed v=%b %h expected v=1 %h", m_axis_tvalid, obs, prev_out);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        assert (obs === {e[25], e[24], 8'h00, e[23:0]}) else begin
          n_err++;
          $error("FAIL beat: observed %h expected %h", obs, {e[25], e[24], 8'h00, e[23:0]});
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = obs;
    end
  end

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] px, input logic s, input logic e);
    valid_in = 1'b1;
    shade_in = px;
    sof_in   = s;
    eol_in   = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    sof_in   = 1'b0;
    eol_in   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    eol_in   = 1'b0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 0);
  endtask

  // stimulus
  initial begin
    logic r;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("rst_tuser", {31'd0, m_axis_tuser}, 0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_ready", {31'd0, ready_out}, 1);
    chk("rst_state", 32'(state_dbg), 32'(WAIT_SOF));

    // 1: beats before sof are discarded, sof beat appears one cycle later
    send(24'h000001, 1'b0, 1'b0);
    send(24'h000002, 1'b0, 1'b0);
    send(24'h000003, 1'b0, 1'b0);
    chk("t1_pre_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("t1_pre_state", 32'(state_dbg), 32'(WAIT_SOF));
`ifdef PACKER_STATS_EN
    chk("t1_drop_count", {16'd0, drop_count}, 0);
`endif
    exp_q.push_back({1'b1, 1'b0, 24'h102030});
    send(24'h102030, 1'b1, 1'b0);
    chk("t1_tvalid", {31'd0, m_axis_tvalid}, 1);
    chk("t1_tdata", m_axis_tdata, 32'h00102030);
    chk("t1_tuser", {31'd0, m_axis_tuser}, 1);
    chk("t1_state", 32'(state_dbg), 32'(STREAM));
    idle(2);

    // 2: 4x2 frame, eol on beats 3 and 7
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({(i == 0), (i == 3 || i == 7), 24'h000100 + 24'(i)});
      send(24'h000100 + 24'(i), (i == 0), (i == 3 || i == 7));
    end
    drain("t2", 20);
    chk("t2_overflow", {31'd0, overflow}, 0);
`ifdef PACKER_STATS_EN
    chk("t2_frame_count", frame_count, 2);
`endif

    // 3: stall downstream and push one beat more than fits
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i == 0), 1'b0, 24'h000300 + 24'(i)});
      send(24'h000300 + 24'(i), (i == 0), 1'b0);
    end
    chk("t3_ready_full", {31'd0, ready_out}, 0);
    chk("t3_ovf_before", {31'd0, overflow}, 0);
    chk("t3_state_before", 32'(state_dbg), 32'(STREAM));
    send(24'h0003FF, 1'b0, 1'b1);
    chk("t3_overflow", {31'd0, overflow}, 1);
    chk("t3_state", 32'(state_dbg), 32'(DROP));
    chk("t3_head_tdata", m_axis_tdata, 32'h00000300);
    chk("t3_head_tuser", {31'd0, m_axis_tuser}, 1);
`ifdef PACKER_STATS_EN
    chk("t3_frame_count", frame_count, 2);
    chk("t3_drop_count", {16'd0, drop_count}, 1);
`endif

    // 4: drain while non-sof beats are discarded, then resync on sof
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(24'h000400 + 24'(i), 1'b0, 1'b0);
    chk("t4_state_drop", 32'(state_dbg), 32'(DROP));
`ifdef PACKER_STATS_EN
    chk("t4_drop_count", {16'd0, drop_count}, 5);
`endif
    exp_q.push_back({1'b1, 1'b0, 24'hABCDEF});
    send(24'hABCDEF, 1'b1, 1'b0);
    chk("t4_state_stream", 32'(state_dbg), 32'(STREAM));
    exp_q.push_back({1'b0, 1'b1, 24'hABCDF0});
    send(24'hABCDF0, 1'b0, 1'b1);
    drain("t4", 40);
`ifdef PACKER_STATS_EN
    chk("t4_frame_count", frame_count, 4);
`endif
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    overflow_clr = 1'b0;
    chk("t4_clr", {31'd0, overflow}, 0);

    // 5: tready alternating with random phase, input at half rate
    for (int i = 0; i < 64; i++) begin
      r = 1'($urandom_range(0, 1));
      m_axis_tready = r;
      exp_q.push_back({(i == 0), (i % 8 == 7), 24'h500000 + 24'(i)});
      send(24'h500000 + 24'(i), (i == 0), (i % 8 == 7));
      m_axis_tready = !r;
      idle(1);
    end
    drain("t5", 20);
    chk("t5_overflow", {31'd0, overflow}, 0);
`ifdef PACKER_STATS_EN
    chk("t5_frame_count", frame_count, 5);
`endif

    // 6: clear coinciding with a new overflow, then clear alone, then reset mid-frame
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({(i == 0), 1'b0, 24'h000600 + 24'(i)});
      send(24'h000600 + 24'(i), (i == 0), 1'b0);
    end
    chk("t6_ready_full", {31'd0, ready_out}, 0);
    overflow_clr = 1'b1;
    send(24'h0006FF, 1'b0, 1'b0);
    overflow_clr = 1'b0;
    chk("t6_set_wins", {31'd0, overflow}, 1);
    chk("t6_state", 32'(state_dbg), 32'(DROP));
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk("t6_clr_alone", {31'd0, overflow}, 0);
`ifdef PACKER_STATS_EN
    chk("t6_drop_count", {16'd0, drop_count}, 6);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("t6_rst_tlast", {31'd0, m_axis_tlast}, 0);
    chk("t6_rst_tdata", m_axis_tdata, 0);
    chk("t6_rst_ready", {31'd0, ready_out}, 1);
    chk("t6_rst_state", 32'(state_dbg), 32'(WAIT_SOF));
`ifdef PACKER_STATS_EN
    chk("t6_rst_frame_count", frame_count, 0);
    chk("t6_rst_drop_count", {16'd0, drop_count}, 0);
`endif

    // after reset: non-sof discarded without counting, next frame streams
    m_axis_tready = 1'b1;
    send(24'h000700, 1'b0, 1'b0);
    chk("t7_discard_tvalid", {31'd0, m_axis_tvalid}, 0);
`ifdef PACKER_STATS_EN
    chk("t7_drop_count", {16'd0, drop_count}, 0);
`endif
    exp_q.push_back({1'b1, 1'b0, 24'h0007AB});
    send(24'h0007AB, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 24'h0007AC});
    send(24'h0007AC, 1'b0, 1'b1);
    drain("t7", 20);
`ifdef PACKER_STATS_EN
    chk("t7_frame_count", frame_count, 1);
`endif

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
